// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush control and saturating
// performance counters for stalls, bubbles and valid instructions.
module pipe_stage_reg #(
    parameter int                CTRL_W      = 11,
    parameter int                DATA_W      = 154,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              CntClr,
    input  logic              ValidIn,
    input  logic [CTRL_W-1:0] CtrlIn,
    input  logic [DATA_W-1:0] DataIn,
    output logic              ValidOut,
    output logic [CTRL_W-1:0] CtrlOut,
    output logic [DATA_W-1:0] DataOut,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  BubbleCnt,
    output logic [CNT_W-1:0]  InstrCnt
);

    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] data_p1;
    logic [CNT_W-1:0]  stallCnt_p1;
    logic [CNT_W-1:0]  bubbleCnt_p1;
    logic [CNT_W-1:0]  instrCnt_p1;

    logic doLoad;
    logic loadBubble;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign doLoad     = !Flush && !Stall;
    assign loadBubble = Flush || (doLoad && !ValidIn);

    // Stage boundary: upstream bundle -> registered bundle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= CTRL_BUBBLE;
            data_p1 <= '0;
        end else if (Flush) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= CTRL_BUBBLE;
            data_p1 <= '0;
        end else if (!Stall) begin
            vld_p1  <= ValidIn;
            // an invalid slot must never carry live write/branch enables
            ctrl_p1 <= ValidIn ? CtrlIn : CTRL_BUBBLE;
            data_p1 <= DataIn;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stallCnt_p1  <= '0;
            bubbleCnt_p1 <= '0;
            instrCnt_p1  <= '0;
        end else if (CntClr) begin
            stallCnt_p1  <= '0;
            bubbleCnt_p1 <= '0;
            instrCnt_p1  <= '0;
        end else begin
            if (Stall && !Flush)
                stallCnt_p1 <= satInc(stallCnt_p1);
            if (loadBubble)
                bubbleCnt_p1 <= satInc(bubbleCnt_p1);
            if (doLoad && ValidIn)
                instrCnt_p1 <= satInc(instrCnt_p1);
        end
    end

    assign ValidOut  = vld_p1;
    assign CtrlOut   = ctrl_p1;
    assign DataOut   = data_p1;
    assign StallCnt  = stallCnt_p1;
    assign BubbleCnt = bubbleCnt_p1;
    assign InstrCnt  = instrCnt_p1;

endmodule
